shifter_secuencial: RTL and testbench

Multi-position sequential shifter. It shifts an N-bit operand by a programmable amount, one position per clock. It supports logical shift, arithmetic shift and rotate, in either direction. It is the clocked successor of the single-position combinational shifter in the ALU datapath, and uses a start/done handshake toward the lab's control FSM.

---
 rtl/shifter_secuencial.sv | 128 ++++++++++++
 tb/tb_shifter_secuencial.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/shifter_secuencial.sv
// shifter_secuencial
// Sequential multi-position shifter. It shifts an N-bit operand one position
// per clock and supports logical shift, arithmetic shift and rotate, in either
// direction. It is started with a start/done handshake.
//
// Ports:
//   clk     in   system clock; every state update happens on the rising edge
//   rst     in   synchronous active-high reset; it overrides everything
//   start   in   request pulse; it is sampled only in IDLE or DONE
//   A       in   [N-1:0] operand, captured when start is accepted
//   amount  in   [W-1:0] shift distance, captured together with A
//   mode    in   [1:0] 00 logical, 01 arithmetic, 10 rotate, 11 logical
//   dir     in   0 = left, 1 = right; captured together with A
//   Y       out  [N-1:0] result register
//   busy    out  high while shifting
//   done    out  one-cycle pulse while Y holds a fresh result
module shifter_secuencial #(
    parameter int N = 8,
    localparam int W = $clog2(N) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [W-1:0] amount,
    input  logic [1:0]   mode,
    input  logic         dir,
    output logic [N-1:0] Y,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [W-1:0] N_W = W'(N);

    state_t       state, state_next;
    logic [W-1:0] count;
    logic         rot_q;
    logic         arith_q;
    logic         right_q;
    logic         accept;
    logic         is_rot;
    logic [W-1:0] k_new;

    // Shifting N or more places leaves nothing of the operand, so a logical or
    // arithmetic count saturates at N. A rotate by N is the identity, so the
    // rotate count is taken modulo N.
    function automatic logic [W-1:0] eff_count(input logic [W-1:0] amt,
                                               input logic rot);
        logic [31:0] wrapped;
        wrapped = 32'(amt) % N;
        if (rot)
            return wrapped[W-1:0];
        else
            return (amt >= N_W) ? N_W : amt;
    endfunction

    // Single-position step. A left arithmetic shift is the same as a left
    // logical shift, so the arithmetic flag only matters for right shifts.
    function automatic logic [N-1:0] step(input logic [N-1:0] v,
                                          input logic arith,
                                          input logic rot,
                                          input logic right);
        logic signed [N-1:0] sv;
        sv = v;
        if (right) begin
            if (rot)
                return {v[0], v[N-1:1]};
            else if (arith)
                return sv >>> 1;
            else
                return {1'b0, v[N-1:1]};
        end else begin
            if (rot)
                return {v[N-2:0], v[N-1]};
            else
                return {v[N-2:0], 1'b0};
        end
    endfunction

    assign is_rot = (mode == 2'b10);
    assign k_new  = eff_count(amount, is_rot);
    assign accept = start && (state != SHIFT);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (k_new != '0) ? SHIFT : DONE;
            SHIFT:   if (count == W'(1)) state_next = DONE;
            DONE: begin
                if (start) state_next = (k_new != '0) ? SHIFT : DONE;
                else       state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Capture happens in IDLE or DONE, and shifting happens only in SHIFT.
    // Anything driven on the inputs while shifting is therefore ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            Y       <= '0;
            count   <= '0;
            rot_q   <= 1'b0;
            arith_q <= 1'b0;
            right_q <= 1'b0;
        end else if (accept) begin
            Y       <= A;
            count   <= k_new;
            rot_q   <= is_rot;
            arith_q <= (mode == 2'b01);
            right_q <= dir;
        end else if (state == SHIFT) begin
            Y     <= step(Y, arith_q, rot_q, right_q);
            count <= count - W'(1);
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_shifter_secuencial.sv
module tb_shifter_secuencial;

    localparam int N = 8;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] A;
    logic [W-1:0] amount;
    logic [1:0]   mode;
    logic         dir;
    logic [N-1:0] Y;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    shifter_secuencial #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .amount(amount),
        .mode(mode), .dir(dir), .Y(Y), .busy(busy), .done(done)
    );

    typedef struct {
        logic [7:0] y;
        int         lat;
        int         nbusy;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int keff(input logic [3:0] amt, input logic [1:0] m);
        if (m == 2'b10) return int'(amt) % 8;
        return (int'(amt) > 8) ? 8 : int'(amt);
    endfunction

    // Reference result computed directly with the language shift operators.
    function automatic logic [7:0] model(input logic [7:0] a, input logic [3:0] amt,
                                         input logic [1:0] m, input logic d);
        logic signed [7:0] s;
        logic [7:0] r;
        int k;
        s = a;
        if (m == 2'b10) begin
            k = int'(amt) % 8;
            if (d) r = (a >> k) | (a << (8 - k));
            else   r = (a << k) | (a >> (8 - k));
        end else if (m == 2'b01 && d) begin
            r = s >>> amt;
        end else begin
            r = d ? (a >> amt) : (a << amt);
        end
        return r;
    endfunction

    // Called at a negedge. Returns at the next negedge, after the launch edge.
    task automatic start_op(input logic [7:0] a, input logic [3:0] amt,
                            input logic [1:0] m, input logic d);
        exp_t e;
        e.y     = model(a, amt, m, d);
        e.lat   = keff(amt, m) + 1;
        e.nbusy = keff(amt, m);
        sb.push_back(e);
        A = a; amount = amt; mode = m; dir = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for done, then compares the result against the scoreboard.
    // With inject set, it drives a stray start with other operands during SHIFT.
    task automatic finish_op(input string tag, input bit inject);
        int   edges = 1;
        int   nb = 0;
        exp_t e;
        while (!done && edges < 40) begin
            if (busy) nb++;
            if (inject && edges == 1) begin
                A = 8'hFF; amount = 4'd1; mode = 2'b10; dir = 1'b1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            edges++;
        end
        start = 1'b0;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_y"}, 32'(Y), 32'(e.y));
            check({tag, "_latency"}, edges, e.lat);
            check({tag, "_busy_cycles"}, nb, e.nbusy);
        end
    endtask

    initial begin
        exp_t discard;
        rst = 1'b1; start = 1'b0; A = '0; amount = '0; mode = '0; dir = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_y", 32'(Y), 32'h0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Logical left by 3, then Y must hold once done has dropped.
        start_op(8'b1001_0110, 4'd3, 2'b00, 1'b0);
        finish_op("lsl3", 0);
        @(negedge clk);
        check("hold_y", 32'(Y), 32'hB0);
        check("hold_done", 32'(done), 32'd0);
        check("hold_busy", 32'(busy), 32'd0);

        start_op(8'b1001_0110, 4'd2, 2'b01, 1'b1); finish_op("asr2", 0); @(negedge clk);
        start_op(8'b1001_0110, 4'd2, 2'b01, 1'b0); finish_op("asl2", 0); @(negedge clk);
        start_op(8'b1001_0110, 4'd3, 2'b10, 1'b1); finish_op("ror3", 0); @(negedge clk);
        start_op(8'b1001_0110, 4'd8, 2'b10, 1'b1); finish_op("ror8", 0); @(negedge clk);
        start_op(8'b1001_0110, 4'd3, 2'b10, 1'b0); finish_op("rol3", 0); @(negedge clk);
        start_op(8'b1001_0110, 4'd0, 2'b00, 1'b1); finish_op("lsr0", 0); @(negedge clk);
        start_op(8'b1001_0110, 4'd12, 2'b00, 1'b1); finish_op("lsr12", 0); @(negedge clk);
        start_op(8'b1001_0110, 4'd2, 2'b11, 1'b1); finish_op("m11_lsr2", 0); @(negedge clk);
        start_op(8'b1001_0110, 4'd15, 2'b01, 1'b1); finish_op("asr15", 0); @(negedge clk);

        // Stray start while shifting, then a back-to-back start in the DONE cycle.
        start_op(8'b1001_0110, 4'd3, 2'b00, 1'b0);
        finish_op("ignore_mid", 1);
        start_op(8'h81, 4'd3, 2'b10, 1'b0);
        finish_op("back2back", 0);
        @(negedge clk);

        // Reset asserted during the second SHIFT cycle.
        start_op(8'b1001_0110, 4'd5, 2'b00, 1'b0);
        @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_y", 32'(Y), 32'h0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        if (sb.size() != 0) discard = sb.pop_front();
        @(negedge clk);
        check("post_rst_idle_busy", 32'(busy), 32'd0);
        check("post_rst_idle_done", 32'(done), 32'd0);
        start_op(8'h81, 4'd1, 2'b01, 1'b1);
        finish_op("after_rst_asr1", 0);
        check("after_rst_value", 32'(Y), 32'hC0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
